wishbone_bus_arbiter: RTL
=========================

Name: wishbone_bus_arbiter

Overview:
- Shares one Wishbone classic slave port between NUM_MASTERS requesters, e.g. instruction fetch and the data-side Wishbone master.
- Grant is cycle-based: the owner keeps the bus for as long as it holds cyc, which covers held-cyc LR sequences.
- An optional hold limit preempts an owner that idles with cyc high and stb low while another master waits. The owner is told its exclusivity was lost.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- FIXED_PRIORITY, 0: 0 means round-robin; 1 means the lowest index wins.
- MAX_HOLD, 32, idle cycles (cyc=1, stb=0) an owner may hold while another master waits; 0 disables preemption.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_cyc  in  NUM_MASTERS  per-master cyc
- m_stb  in  NUM_MASTERS  per-master stb
- m_we  in  NUM_MASTERS  per-master we
- m_adr  in  NUM_MASTERS x 32  per-master address
- m_sel  in  NUM_MASTERS x 4  per-master byte select
- m_dat_w  in  NUM_MASTERS x 32  per-master write data
- m_ack  out  NUM_MASTERS  ack, routed to the owner only
- m_dat_r  out  32  read data, broadcast to all masters
- m_lost  out  NUM_MASTERS  one-cycle pulse to a preempted owner
- s_cyc, s_stb, s_we  out  1  slave control
- s_adr  out  32  slave address
- s_sel  out  4  slave byte select
- s_dat_w  out  32  slave write data
- s_ack  in  1  slave ack
- s_dat_r  in  32  slave read data
- grant  out  NUM_MASTERS  one-hot owner; 0 when idle
- busy  out  1  high when state is OWNED

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0, rr_ptr=0, hold_cnt=0, m_lost=0.
  - All s_* outputs are 0.
- Slave-side mux:
  - Combinational from the registered grant.
  - With no grant, s_cyc, s_stb, s_we, s_adr, s_sel and s_dat_w are all 0.
  - m_ack[i] = s_ack & grant[i].
  - m_dat_r = s_dat_r, unqualified.
- IDLE state:
  - If any m_cyc is set, pick a winner: the lowest index if FIXED_PRIORITY=1, otherwise the first requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - At the next edge: grant<=onehot(winner), state<=OWNED, hold_cnt<=0.
  - Latency: a master sees s_cyc follow its own cyc exactly one cycle after its first request from IDLE.
- OWNED state, owner index g:
  - Release: if m_cyc[g]=0, then state<=IDLE, grant<=0, rr_ptr<=(g+1) mod NUM_MASTERS. At least one idle cycle separates two owners.
  - Hold counting: if m_cyc[g]=1 and m_stb[g]=0 and any other m_cyc is set, hold_cnt increments, saturating at MAX_HOLD. Otherwise hold_cnt<=0.
  - Preemption: if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and the same conditions hold, then grant<=0, state<=IDLE, m_lost[g]<=1 for one cycle, rr_ptr<=(g+1) mod NUM_MASTERS.
  - Never preempt while m_stb[g]=1, so an in-flight transfer always completes.
  - A preempted master keeps cyc high and is re-arbitrated normally.
- Simultaneous events:
  - Owner drops cyc in the same cycle the preempt condition is met: release wins, and m_lost stays 0.
  - s_ack in the cycle the owner drops cyc: the ack is still delivered, since grant is still registered that cycle.
- Protocol guards:
  - s_ack while grant=0 is ignored and no m_ack is raised. It is an assertion failure in verification.
  - A non-owner's stb is never visible on the slave port.
- Reset mid-transfer: everything clears immediately (async). The slave must tolerate cyc dropping.

Test Plan:
- Single master 0: assert m_cyc/m_stb with adr=0x100, read; slave acks in cycle 3 with dat_r=0xDEADBEEF -> s_cyc rises one cycle after m_cyc, m_ack[0] pulses, m_dat_r=0xDEADBEEF, m_ack[1]=0 throughout.
- Round-robin, FIXED_PRIORITY=0: both masters hold cyc for back-to-back single transfers -> grants alternate 0,1,0,1 with one idle cycle between owners. With FIXED_PRIORITY=1, master 0 always wins.
- LR hold, MAX_HOLD=4: master 1 reads, keeps cyc high with stb=0, master 0 requests -> master 1 preempted on the 4th idle cycle, m_lost[1]=1 for one cycle, grant=01 two cycles later.
- Preempt blocked by stb: master 1 keeps stb high past MAX_HOLD with ack delayed 10 cycles -> no preemption, m_lost=0, master 1 gets its ack.
- Release/preempt tie: owner drops cyc in exactly the cycle hold_cnt reaches MAX_HOLD-1 -> normal release, m_lost=0.
- Async reset mid-transfer: pull rst_n low while stb is high -> grant=0, s_cyc=0, busy=0 without waiting for a clock edge. After release, the first arbitration starts at rr_ptr=0.

Source files
------------

// File: rtl/wishbone_bus_arbiter_if.sv
// Wishbone classic signal bundle for N ports. The master modport issues cycles
// and the slave modport answers them.
interface wishbone_bus_arbiter_if #(
    parameter int N = 1
);
    logic [N-1:0]       cyc;
    logic [N-1:0]       stb;
    logic [N-1:0]       we;
    logic [N-1:0][31:0] adr;
    logic [N-1:0][3:0]  sel;
    logic [N-1:0][31:0] dat_w;
    logic [N-1:0]       ack;
    logic [31:0]        dat_r;

    modport master (output cyc, stb, we, adr, sel, dat_w, input ack, dat_r);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output ack, dat_r);
endinterface

// File: rtl/wishbone_bus_arbiter.sv
// Cycle-based arbiter sharing one Wishbone classic slave between NUM_MASTERS
// requesters, with optional preemption of an owner that idles while others wait.
module wishbone_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int MAX_HOLD       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wishbone_bus_arbiter_if.slave  m,
    wishbone_bus_arbiter_if.master s,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [NUM_MASTERS-1:0] m_lost,
    output logic                   busy
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [IW:0]   NM         = (IW + 1)'(NUM_MASTERS);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_MASTERS - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST  = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit            PREEMPT_EN = (MAX_HOLD > 0);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t        state;
    logic [IW-1:0] owner_idx;
    logic [IW-1:0] rr_ptr;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] winner;
    logic [IW-1:0] next_rr;
    logic          found;
    logic          owner_cyc;
    logic          owner_stb;
    logic          others_wait;
    logic          idle_wait;
    logic          preempt;

    // NOTE: every variable written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            logic [IW:0] cand;
            cand = FIXED_PRIORITY ? (IW + 1)'(k) : {1'b0, rr_ptr} + (IW + 1)'(k);
            if (cand >= NM) cand = cand - NM;
            if (!found && m.cyc[cand[IW-1:0]]) begin
                winner = cand[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign owner_cyc   = m.cyc[owner_idx];
    assign owner_stb   = m.stb[owner_idx];
    assign others_wait = |(m.cyc & ~grant);
    // An owner only accrues hold time between transfers, never with stb in flight.
    assign idle_wait   = owner_cyc & ~owner_stb & others_wait;
    assign preempt     = PREEMPT_EN & idle_wait & (hold_cnt == HOLD_LAST);
    assign next_rr     = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;
    assign busy        = (state == OWNED);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            owner_idx <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            m_lost    <= '0;
        end else begin
            m_lost <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= OWNED;
                        grant     <= NUM_MASTERS'(1) << winner;
                        owner_idx <= winner;
                        hold_cnt  <= '0;
                    end
                end
                OWNED: begin
                    if (!owner_cyc) begin
                        state    <= IDLE;
                        grant    <= '0;
                        rr_ptr   <= next_rr;
                        hold_cnt <= '0;
                    end else if (preempt) begin
                        state    <= IDLE;
                        grant    <= '0;
                        rr_ptr   <= next_rr;
                        hold_cnt <= '0;
                        m_lost   <= grant;
                    end else if (idle_wait) begin
                        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s.cyc   = '0;
        s.stb   = '0;
        s.we    = '0;
        s.adr   = '0;
        s.sel   = '0;
        s.dat_w = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                s.cyc   = m.cyc[i];
                s.stb   = m.stb[i];
                s.we    = m.we[i];
                s.adr   = m.adr[i];
                s.sel   = m.sel[i];
                s.dat_w = m.dat_w[i];
            end
        end
    end

    assign m.ack   = grant & {NUM_MASTERS{s.ack}};
    assign m.dat_r = s.dat_r;
endmodule
